wb_master_sequencer: RTL and testbench
======================================

# wb_master_sequencer

Wishbone initiator that turns single register commands from a local requester into Wishbone read/write cycles against the FPGA register slaves, such as the control and clock-divider register bank. It runs at most one transaction at a time. Each transaction returns one response carrying read data or an error flag. A timeout aborts cycles that a slave never acknowledges. It sits between an on-fabric command source (test sequencer, bring-up logic) and the shared Wishbone slave bus.

## Interface
Parameters:
- ADDRWIDTH, 7, word address width; matches the slave register map.
- DATAWIDTH, 32, data bus width.
- TIMEOUT_CYCLES, 255, bus cycles to wait for ACK before abort (1..255).

Ports:
- WBs_CLK_i  in  1  bus clock; all logic on its rising edge.
- WBs_RST_n_i  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDRWIDTH  target word address.
- cmd_sel_i  in  4  byte enables.
- cmd_dat_i  in  DATAWIDTH  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  DATAWIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  transaction timed out.
- WBm_CYC_o, WBm_STB_o, WBm_WE_o  out  1 each  Wishbone cycle, strobe and write-enable.
- WBm_ADR_o  out  ADDRWIDTH  address.
- WBm_BYTE_STB_o  out  4  byte select.
- WBm_DAT_o  out  DATAWIDTH  write data.
- WBm_DAT_i  in  DATAWIDTH  read data.
- WBm_ACK_i  in  1  slave acknowledge.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM has three states:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i & cmd_ready_o, latch we/adr/sel/dat, clear the timeout counter and go to BUS.
  - BUS: CYC, STB, WE, ADR, BYTE_STB and DAT_o are all registered and held stable. cmd_ready_o = 0.
    - On WBm_ACK_i = 1: capture WBm_DAT_i into rsp_dat_o for reads (0 for writes), set rsp_err_o = 0, go to RESP. CYC/STB drop at the same edge.
    - On timeout: rsp_dat_o = 0, rsp_err_o = 1, go to RESP, CYC/STB drop.
  - RESP: rsp_valid_o = 1 and the response fields are held until rsp_ready_i = 1, then go to IDLE.
- All bus outputs are registered. Reset values: every output is 0 except cmd_ready_o = 1. FSM resets to IDLE.
- WBm_DAT_o and WBm_WE_o are 0 during reads. The ADR, BYTE_STB and DAT_o outputs keep their last values while CYC = 0.
- WBm_ACK_i is ignored outside BUS. A stray ACK never creates a response.
- The timeout counter is 8 bits and increments every BUS cycle without ACK. The abort fires when count == TIMEOUT_CYCLES - 1. If ACK arrives in the same cycle as the timeout, ACK wins and rsp_err_o = 0.
- Asynchronous reset mid-transaction drops CYC/STB immediately; the transaction is discarded with no response.

## Timing
- Command accepted at edge 0, CYC/STB high after edge 0.
- With a registered-ACK slave (ACK one cycle after STB), ACK is sampled at edge 2. rsp_valid_o is high after edge 2 and CYC/STB are low after edge 2.
- Cycle is exactly 2 clocks of CYC. The slave's ~ACK qualifier prevents a double write.
- If rsp_ready_i is held high, the next command is accepted at the edge after the response, giving a minimum of 4 clocks per transaction.
- Timeout response appears TIMEOUT_CYCLES clocks after CYC rises.

## Configuration
- WB_MASTER_TIMEOUT_EN:
  - Defined: timeout counter is present and rsp_err_o behaves as above.
  - Undefined: no counter, BUS waits indefinitely for ACK, and rsp_err_o is tied to 0.

## Structure
- Package wb_master_pkg holds:
  - the state encoding (IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2);
  - the default ADDRWIDTH, DATAWIDTH and TIMEOUT_CYCLES constants;
  - the slave address constants (signature 0x00, revision 0x01, scratch 0x02, control 0x04, clkdiv 0x05) shared with the testbench.
- One sub-module, wb_master_timeout, contains the counter with clear, enable and expire outputs. It is instantiated only under WB_MASTER_TIMEOUT_EN.

## Test plan
- Read address 0x00 from the register slave → rsp_dat_o = 0x0000FEED, rsp_err_o = 0, rsp_valid_o 2 clocks after accept.
- Write 0x12345678 with sel 4'b1111 to 0x04, then read 0x04 → 0x12345678. CYC is high exactly 2 clocks per cycle.
- Write 0xAABBCCDD with sel 4'b0101 to 0x05 after reset, then read → 0x00BB00DD.
- Read unmapped address 0x7F with the slave never asserting ACK and TIMEOUT_CYCLES = 16 → rsp_err_o = 1, rsp_dat_o = 0, response 16 clocks after CYC rises. A late ACK is ignored.
- Hold rsp_ready_i low for 5 clocks → response stays stable, cmd_ready_o stays 0, and a pending cmd_valid_i is not accepted until the response is consumed.
- Assert WBs_RST_n_i low while in BUS → CYC/STB go low immediately (combinationally), cmd_ready_o = 1 and no response is produced.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone master sequencer: FSM encoding, default
// geometry and the register-slave address map used by the bus and its bench.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDRWIDTH      = 7;
    localparam int DEF_DATAWIDTH      = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int SEL_WIDTH          = 4;

    localparam logic [6:0] ADR_SIGNATURE = 7'h00;
    localparam logic [6:0] ADR_REVISION  = 7'h01;
    localparam logic [6:0] ADR_SCRATCH   = 7'h02;
    localparam logic [6:0] ADR_CONTROL   = 7'h04;
    localparam logic [6:0] ADR_CLKDIV    = 7'h05;

    localparam logic [31:0] SIGNATURE_VALUE = 32'h0000_FEED;
    localparam logic [31:0] REVISION_VALUE  = 32'h0001_0002;

    // Byte-lane merge as a register slave applies a partial write.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_master_timeout.sv
// Saturating 8-bit bus-cycle counter; expire is high once TIMEOUT_CYCLES-1
// un-acknowledged cycles have been counted since the last clear.
module wb_master_timeout
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (count_reg == LIMIT);

endmodule

// File: rtl/wb_master_sequencer.sv
// Single-outstanding Wishbone initiator: one command in, one bus cycle, one response out.
// Optional ACK timeout is built only when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_sequencer
    import wb_master_pkg::*;
#(
    parameter int ADDRWIDTH      = DEF_ADDRWIDTH,
    parameter int DATAWIDTH      = DEF_DATAWIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [SEL_WIDTH-1:0] cmd_sel_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic [SEL_WIDTH-1:0] WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,
    output logic                 busy_o
);

    state_t                 state_reg,   state_next;
    logic                   cyc_reg,     cyc_next;
    logic                   we_reg,      we_next;
    logic [ADDRWIDTH-1:0]   adr_reg,     adr_next;
    logic [SEL_WIDTH-1:0]   sel_reg,     sel_next;
    logic [DATAWIDTH-1:0]   dat_reg,     dat_next;
    logic [DATAWIDTH-1:0]   rsp_dat_reg, rsp_dat_next;
    logic                   rsp_err_reg, rsp_err_next;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expire;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (WBs_CLK_i),
        .rst_n  (WBs_RST_n_i),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );
`else
    // Without the counter the bus waits for ACK forever; error never asserts.
    logic unused_tmo;
    assign tmo_expire = 1'b0;
    assign unused_tmo = tmo_clear ^ tmo_enable ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        we_next      = we_reg;
        adr_next     = adr_reg;
        sel_next     = sel_reg;
        dat_next     = dat_reg;
        rsp_dat_next = rsp_dat_reg;
        rsp_err_next = rsp_err_reg;
        tmo_clear    = 1'b0;
        tmo_enable   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_next = BUS;
                    cyc_next   = 1'b1;
                    we_next    = cmd_we_i;
                    adr_next   = cmd_adr_i;
                    sel_next   = cmd_sel_i;
                    dat_next   = cmd_we_i ? cmd_dat_i : '0;
                    tmo_clear  = 1'b1;
                end
            end
            BUS: begin
                tmo_enable = !WBm_ACK_i;
                // ACK takes priority over a timeout expiring in the same cycle.
                if (WBm_ACK_i) begin
                    state_next   = RESP;
                    cyc_next     = 1'b0;
                    we_next      = 1'b0;
                    rsp_dat_next = we_reg ? '0 : WBm_DAT_i;
                    rsp_err_next = 1'b0;
                end else if (tmo_expire) begin
                    state_next   = RESP;
                    cyc_next     = 1'b0;
                    we_next      = 1'b0;
                    rsp_dat_next = '0;
                    rsp_err_next = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
                we_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_reg   <= IDLE;
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            adr_reg     <= '0;
            sel_reg     <= '0;
            dat_reg     <= '0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            we_reg      <= we_next;
            adr_reg     <= adr_next;
            sel_reg     <= sel_next;
            dat_reg     <= dat_next;
            rsp_dat_reg <= rsp_dat_next;
            rsp_err_reg <= rsp_err_next;
        end
    end

    assign cmd_ready_o    = (state_reg == IDLE);
    assign busy_o         = (state_reg != IDLE);
    assign rsp_valid_o    = (state_reg == RESP);
    assign rsp_dat_o      = rsp_dat_reg;
    assign rsp_err_o      = rsp_err_reg;
    assign WBm_CYC_o      = cyc_reg;
    assign WBm_STB_o      = cyc_reg;
    assign WBm_WE_o       = we_reg;
    assign WBm_ADR_o      = adr_reg;
    assign WBm_BYTE_STB_o = sel_reg;
    assign WBm_DAT_o      = dat_reg;

endmodule

// File: tb/tb_wb_master_sequencer.sv
// Bench for wb_master_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a register-map reference model.
module tb_wb_master_sequencer;
    import wb_master_pkg::*;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [3:0]    cmd_sel = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_master_sequencer #(
        .ADDRWIDTH      (AW),
        .DATAWIDTH      (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_n_i    (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_we_i       (cmd_we),
        .cmd_adr_i      (cmd_adr),
        .cmd_sel_i      (cmd_sel),
        .cmd_dat_i      (cmd_dat),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_dat_o      (rsp_dat),
        .rsp_err_o      (rsp_err),
        .WBm_CYC_o      (wb_cyc),
        .WBm_STB_o      (wb_stb),
        .WBm_WE_o       (wb_we),
        .WBm_ADR_o      (wb_adr),
        .WBm_BYTE_STB_o (wb_sel),
        .WBm_DAT_o      (wb_dat_o),
        .WBm_DAT_i      (wb_dat_i),
        .WBm_ACK_i      (wb_ack),
        .busy_o         (busy)
    );

    // ---------------- register slave (registered ACK, optional wait states)
    logic [DW-1:0] slv_regs [0:127];
    logic          slv_ack = 1'b0;
    logic [DW-1:0] slv_rdat = '0;
    logic          stray_ack = 1'b0;
    int            slv_waits = 0;
    int            slv_wcnt = 0;

    assign wb_ack   = slv_ack | stray_ack;
    assign wb_dat_i = slv_rdat;

    function automatic logic is_mapped(input logic [AW-1:0] a);
        return (a == ADR_SIGNATURE) || (a == ADR_REVISION) || (a == ADR_SCRATCH) ||
               (a == ADR_CONTROL) || (a == ADR_CLKDIV);
    endfunction

    function automatic logic is_writable(input logic [AW-1:0] a);
        return (a == ADR_SCRATCH) || (a == ADR_CONTROL) || (a == ADR_CLKDIV);
    endfunction

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && !slv_ack && is_mapped(wb_adr)) begin
            if (slv_wcnt >= slv_waits) begin
                slv_ack  <= 1'b1;
                slv_wcnt <= 0;
                if (wb_we) begin
                    if (is_writable(wb_adr)) begin
                        slv_regs[wb_adr] <= byte_merge(slv_regs[wb_adr], wb_dat_o, wb_sel);
                    end
                    slv_rdat <= '0;
                end else begin
                    slv_rdat <= slv_regs[wb_adr];
                end
            end else begin
                slv_wcnt <= slv_wcnt + 1;
            end
        end else begin
            slv_ack <= 1'b0;
            if (!wb_cyc) slv_wcnt <= 0;
        end
    end

    // ---------------- reference model: register file with byte masks
    logic [DW-1:0] mdl [0:127];

    task automatic model_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                             input logic [DW-1:0] dat, output logic [DW-1:0] edat);
        logic [DW-1:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        if (we) begin
            if (is_writable(adr)) mdl[adr] = (mdl[adr] & ~mask) | (dat & mask);
            edat = '0;
        end else begin
            edat = mdl[adr];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a command at a negedge, returns at the negedge after the accept edge.
    task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                            input logic [DW-1:0] dat);
        int n;
        cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bus_cyc", 64'(wb_cyc), 64'd1);
        chk("bus_stb", 64'(wb_stb), 64'd1);
        chk("bus_we", 64'(wb_we), 64'(we));
        chk("bus_adr", 64'(wb_adr), 64'(adr));
        chk("bus_sel", 64'(wb_sel), 64'(sel));
        chk("bus_dat", 64'(wb_dat_o), we ? 64'(dat) : 64'd0);
    endtask

    task automatic wait_rsp(output int lat, output int cyc_cnt);
        lat = 0; cyc_cnt = 0;
        while (!rsp_valid && lat < 400) begin
            if (wb_cyc) cyc_cnt++;
            @(negedge clk);
            lat++;
        end
        chk("rsp_arrived", 64'(rsp_valid), 64'd1);
        chk("cyc_dropped", 64'(wb_cyc), 64'd0);
    endtask

    task automatic consume(input int rdy_delay);
        repeat (rdy_delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", 64'(rsp_valid), 64'd0);
    endtask

    task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                          input logic [DW-1:0] dat, input int rdy_delay,
                          output logic [DW-1:0] rdat, output logic rerr,
                          output int lat, output int cyc_cnt);
        send_cmd(we, adr, sel, dat);
        wait_rsp(lat, cyc_cnt);
        rdat = rsp_dat;
        rerr = rsp_err;
        consume(rdy_delay);
        $display("txn we=%0b adr=%02h sel=%04b wdat=%08h -> rdat=%08h err=%0b lat=%0d cyc=%0d",
                 we, adr, sel, dat, rdat, rerr, lat, cyc_cnt);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [3:0]    sel;
        logic [DW-1:0] dat;
        logic [DW-1:0] exp_dat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rdat, edat, hold_dat;
        logic          rerr, seen, stable;
        int            lat, cc, w, d;
        logic [AW-1:0] adr_pool [5];

        for (int i = 0; i < 128; i++) begin
            slv_regs[i] = '0;
            mdl[i] = '0;
        end
        slv_regs[ADR_SIGNATURE] = SIGNATURE_VALUE;
        slv_regs[ADR_REVISION]  = REVISION_VALUE;
        mdl[ADR_SIGNATURE] = 32'h0000_FEED;
        mdl[ADR_REVISION]  = 32'h0001_0002;

        vecs[0] = '{1'b0, 7'h00, 4'b1111, 32'h0,           32'h0000_FEED};
        vecs[1] = '{1'b1, 7'h04, 4'b1111, 32'h1234_5678,   32'h0};
        vecs[2] = '{1'b0, 7'h04, 4'b1111, 32'h0,           32'h1234_5678};
        vecs[3] = '{1'b1, 7'h05, 4'b0101, 32'hAABB_CCDD,   32'h0};
        vecs[4] = '{1'b0, 7'h05, 4'b1111, 32'h0,           32'h00BB_00DD};
        vecs[5] = '{1'b0, 7'h01, 4'b1111, 32'h0,           32'h0001_0002};
        vecs[6] = '{1'b1, 7'h02, 4'b1010, 32'hCAFE_BABE,   32'h0};
        vecs[7] = '{1'b0, 7'h02, 4'b1111, 32'h0,           32'hCA00_BA00};

        // Reset state
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_cyc", 64'(wb_cyc), 64'd0);
        chk("rst_stb", 64'(wb_stb), 64'd0);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_adr", 64'(wb_adr), 64'd0);
        chk("rst_sel", 64'(wb_sel), 64'd0);
        chk("rst_dat", 64'(wb_dat_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_dat", 64'(rsp_dat), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table, registered-ACK slave with no wait states
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 0, rdat, rerr, lat, cc);
            model_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, edat);
            chk("vec_rdat", 64'(rdat), 64'(vecs[i].exp_dat));
            chk("vec_err", 64'(rerr), 64'd0);
            chk("vec_latency", 64'(lat), 64'd2);
            chk("vec_cyc_clocks", 64'(cc), 64'd2);
        end

        // Response held for 5 clocks with the next command already pending
        cmd_we = 1'b0; cmd_adr = ADR_CONTROL; cmd_sel = 4'hF; cmd_dat = '0; cmd_valid = 1'b1;
        @(negedge clk);
        chk("hold_accept", 64'(wb_cyc), 64'd1);
        cmd_adr = ADR_CLKDIV;
        wait_rsp(lat, cc);
        hold_dat = rsp_dat;
        chk("hold_rdat", 64'(hold_dat), 64'h1234_5678);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dat !== hold_dat || cmd_ready || wb_cyc) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_back_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pending_cyc", 64'(wb_cyc), 64'd1);
        chk("pending_adr", 64'(wb_adr), 64'(ADR_CLKDIV));
        wait_rsp(lat, cc);
        chk("pending_rdat", 64'(rsp_dat), 64'h00BB_00DD);
        consume(0);

`ifdef WB_MASTER_TIMEOUT_EN
        // Unmapped address: slave never acknowledges
        send_cmd(1'b0, 7'h7F, 4'hF, '0);
        wait_rsp(lat, cc);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_rdat", 64'(rsp_dat), 64'd0);
        chk("tmo_latency", 64'(lat), 64'(TMO));
        chk("tmo_cyc_clocks", 64'(cc), 64'(TMO));
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        chk("late_ack_err", 64'(rsp_err), 64'd1);
        chk("late_ack_valid", 64'(rsp_valid), 64'd1);
        consume(0);
        $display("txn timeout adr=7f err=%0b lat=%0d", 1'b1, lat);
        // ACK arriving on the very cycle the timeout would fire
        slv_waits = TMO - 2;
        do_txn(1'b0, ADR_CONTROL, 4'hF, '0, 0, rdat, rerr, lat, cc);
        chk("tie_err", 64'(rerr), 64'd0);
        chk("tie_rdat", 64'(rdat), 64'h1234_5678);
        chk("tie_latency", 64'(lat), 64'(TMO));
        slv_waits = 0;
`else
        // Without a timeout a slow slave is simply waited for
        slv_waits = 20;
        do_txn(1'b0, ADR_CONTROL, 4'hF, '0, 0, rdat, rerr, lat, cc);
        chk("slow_err", 64'(rerr), 64'd0);
        chk("slow_rdat", 64'(rdat), 64'h1234_5678);
        chk("slow_latency", 64'(lat), 64'd22);
        slv_waits = 0;
`endif

        // Stray ACK while idle never creates a response
        stray_ack = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid || busy) seen = 1'b1; end
        stray_ack = 1'b0;
        chk("stray_ack_idle", 64'(seen), 64'd0);

        // Asynchronous reset while the cycle is on the bus
        slv_waits = 3;
        cmd_we = 1'b0; cmd_adr = ADR_SCRATCH; cmd_sel = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(wb_cyc), 64'd0);
        chk("rst_mid_stb", 64'(wb_stb), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (rsp_valid || wb_cyc) seen = 1'b1; end
        chk("rst_mid_no_rsp", 64'(seen), 64'd0);
        $display("txn reset-abort adr=%02h discarded", ADR_SCRATCH);
        slv_waits = 0;

        // Randomized traffic against the reference model
        adr_pool[0] = ADR_SIGNATURE; adr_pool[1] = ADR_REVISION; adr_pool[2] = ADR_SCRATCH;
        adr_pool[3] = ADR_CONTROL;   adr_pool[4] = ADR_CLKDIV;
        for (int i = 0; i < 40; i++) begin
            logic          r_we;
            logic [AW-1:0] r_adr;
            logic [3:0]    r_sel;
            logic [DW-1:0] r_dat;
            r_we  = 1'($urandom_range(0, 1));
            r_adr = adr_pool[$urandom_range(0, 4)];
            r_sel = 4'($urandom_range(0, 15));
            r_dat = $urandom;
            w = $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            slv_waits = w;
            model_txn(r_we, r_adr, r_sel, r_dat, edat);
            do_txn(r_we, r_adr, r_sel, r_dat, d, rdat, rerr, lat, cc);
            chk("rand_rdat", 64'(rdat), 64'(edat));
            chk("rand_err", 64'(rerr), 64'd0);
            chk("rand_latency", 64'(lat), 64'(2 + w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
